// File: rtl/memory_copier_rtl_chunked_dma.sv
// Chunked memory copier for the ESP DMA socket: read burst into local buffer, then write burst.
// Latency: one cycle per ctrl handshake and per beat; acc_done pulses 2 cycles after the last write beat.
// Backpressure: every valid is held until its ready; read data is only accepted while in RD_DATA.
module memory_copier_rtl_chunked_dma #(
    parameter int DATA_W     = 32,
    parameter int CHUNK_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       conf_info_len,
    input  logic [31:0]       conf_info_src_offset,
    input  logic [31:0]       conf_info_dst_offset,
    input  logic              conf_done,
    output logic              dma_read_ctrl_valid,
    input  logic              dma_read_ctrl_ready,
    output logic [31:0]       dma_read_ctrl_data_index,
    output logic [31:0]       dma_read_ctrl_data_length,
    output logic [2:0]        dma_read_ctrl_data_size,
    output logic [4:0]        dma_read_ctrl_data_user,
    input  logic              dma_read_chnl_valid,
    output logic              dma_read_chnl_ready,
    input  logic [DATA_W-1:0] dma_read_chnl_data,
    output logic              dma_write_ctrl_valid,
    input  logic              dma_write_ctrl_ready,
    output logic [31:0]       dma_write_ctrl_data_index,
    output logic [31:0]       dma_write_ctrl_data_length,
    output logic [2:0]        dma_write_ctrl_data_size,
    output logic [4:0]        dma_write_ctrl_data_user,
    output logic              dma_write_chnl_valid,
    input  logic              dma_write_chnl_ready,
    output logic [DATA_W-1:0] dma_write_chnl_data,
    output logic              acc_done,
    output logic [31:0]       debug
);

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_RD_REQ  = 3'd1;
    localparam logic [2:0]  S_RD_DATA = 3'd2;
    localparam logic [2:0]  S_WR_REQ  = 3'd3;
    localparam logic [2:0]  S_WR_DATA = 3'd4;
    localparam logic [2:0]  S_DONE    = 3'd5;

    localparam logic [31:0] CHUNK_BEATS = 32'd1 << CHUNK_LOG2;
    localparam logic [2:0]  BEAT_SIZE   = (DATA_W == 64) ? 3'b011 : 3'b010;

    logic [2:0]        r_state;
    logic              r_armed;
    logic [31:0]       r_src_ptr;
    logic [31:0]       r_dst_ptr;
    logic [31:0]       r_rem;
    logic [31:0]       r_chunk_len;
    logic [31:0]       r_ptr;
    logic [15:0]       r_chunks_done;
    logic              r_acc_done;
    logic [DATA_W-1:0] r_buf [0:(1<<CHUNK_LOG2)-1];

    logic              w_start;
    logic              w_rd_ctrl_hs;
    logic              w_rd_beat;
    logic              w_wr_ctrl_hs;
    logic              w_wr_beat;
    logic              w_chunk_last;
    logic [31:0]       w_rem_after;
    logic [31:0]       w_first_chunk;
    logic [31:0]       w_next_chunk;

    // Handshakes, chunk bookkeeping and the min(rem, chunk) sizing.
    always_comb begin
        w_start       = (r_state == S_IDLE) && conf_done && r_armed;
        w_rd_ctrl_hs  = dma_read_ctrl_valid && dma_read_ctrl_ready;
        w_rd_beat     = dma_read_chnl_valid && dma_read_chnl_ready;
        w_wr_ctrl_hs  = dma_write_ctrl_valid && dma_write_ctrl_ready;
        w_wr_beat     = dma_write_chnl_valid && dma_write_chnl_ready;
        w_chunk_last  = (r_ptr == r_chunk_len - 32'd1);
        w_rem_after   = r_rem - r_chunk_len;
        w_first_chunk = (conf_info_len < CHUNK_BEATS) ? conf_info_len : CHUNK_BEATS;
        w_next_chunk  = (w_rem_after < CHUNK_BEATS) ? w_rem_after : CHUNK_BEATS;
    end

    // Main control FSM with pointer, remaining-count and chunk counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            // A conf_done already high across reset must not start a new copy;
            // it has to drop first. With conf_done low this arms immediately.
            r_armed       <= ~conf_done;
            r_src_ptr     <= 32'd0;
            r_dst_ptr     <= 32'd0;
            r_rem         <= 32'd0;
            r_chunk_len   <= 32'd0;
            r_ptr         <= 32'd0;
            r_chunks_done <= 16'd0;
            r_acc_done    <= 1'b0;
        end else begin
            r_acc_done <= 1'b0;
            if (!conf_done) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_armed       <= 1'b0;
                        r_src_ptr     <= conf_info_src_offset;
                        r_dst_ptr     <= conf_info_dst_offset;
                        r_rem         <= conf_info_len;
                        r_ptr         <= 32'd0;
                        r_chunks_done <= 16'd0;
                        if (conf_info_len == 32'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_chunk_len <= w_first_chunk;
                            r_state     <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (w_rd_ctrl_hs) begin
                        r_state <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_rd_beat) begin
                        if (w_chunk_last) begin
                            r_ptr   <= 32'd0;
                            r_state <= S_WR_REQ;
                        end else begin
                            r_ptr <= r_ptr + 32'd1;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (w_wr_ctrl_hs) begin
                        r_state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_wr_beat) begin
                        if (w_chunk_last) begin
                            r_ptr         <= 32'd0;
                            r_src_ptr     <= r_src_ptr + r_chunk_len;
                            r_dst_ptr     <= r_dst_ptr + r_chunk_len;
                            r_rem         <= w_rem_after;
                            r_chunks_done <= r_chunks_done + 16'd1;
                            if (w_rem_after != 32'd0) begin
                                r_chunk_len <= w_next_chunk;
                                r_state     <= S_RD_REQ;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_ptr <= r_ptr + 32'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_acc_done <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Local chunk buffer, filled beat by beat during the read burst.
    always_ff @(posedge clk) begin
        if (!rst && w_rd_beat) begin
            r_buf[r_ptr[CHUNK_LOG2-1:0]] <= dma_read_chnl_data;
        end
    end

    // Outputs decode straight from registered state so they stay stable between edges.
    always_comb begin
        dma_read_ctrl_valid        = (r_state == S_RD_REQ);
        dma_read_ctrl_data_index   = r_src_ptr;
        dma_read_ctrl_data_length  = r_chunk_len;
        dma_read_ctrl_data_size    = BEAT_SIZE;
        dma_read_ctrl_data_user    = 5'd0;
        dma_read_chnl_ready        = (r_state == S_RD_DATA);
        dma_write_ctrl_valid       = (r_state == S_WR_REQ);
        dma_write_ctrl_data_index  = r_dst_ptr;
        dma_write_ctrl_data_length = r_chunk_len;
        dma_write_ctrl_data_size   = BEAT_SIZE;
        dma_write_ctrl_data_user   = 5'd0;
        dma_write_chnl_valid       = (r_state == S_WR_DATA);
        dma_write_chnl_data        = r_buf[r_ptr[CHUNK_LOG2-1:0]];
        acc_done                   = r_acc_done;
        debug                      = {r_state, 13'd0, r_chunks_done};
    end

endmodule
